multi_tube_tdc: RTL and testbench
=================================

Name: multi_tube_tdc

Overview:
- Multi-channel drift-time counter. Parametrised successor of the single-tube latch-and-count block.
- After a trigger, measures the clock cycles until each tube input first goes high (gated by gate_enable). It then reads out per-channel results serially over a valid/ready handshake.
- Sits between the tube front-end pins and the event-builder/readout FIFO.

Parameters:
- N_TUBES, 8, number of tube channels (1..32).
- CNT_W, 8, width of the time counter and of each stored time.
- WINDOW, 255, last counter value of the measurement window (must be ≤ 2^CNT_W-1).
- SYNC_STAGES, 2, synchroniser flops per tube input (≥2).
- EARLY_DONE, 1, if 1, the window ends as soon as all channels have hit.

Ports:
- clk, input, 1, system clock.
- clr_n, input, 1, asynchronous active-low reset.
- start, input, 1, trigger pulse; begins a measurement when in IDLE.
- abort, input, 1, synchronous soft clear; returns to IDLE from any state.
- gate_enable, input, 1, global hit-capture enable.
- tube_pins, input, N_TUBES, asynchronous tube discriminator outputs.
- busy, output, 1, high in ARMED or READOUT.
- out_valid, output, 1, readout word valid.
- out_ready, input, 1, downstream accepts the word.
- out_chan, output, clog2(N_TUBES) (min 1), channel index of the current word.
- out_hit, output, 1, channel was hit in the window.
- out_time, output, CNT_W, captured time for the channel.

Behaviour:
- Reset (clr_n low, async):
  - state=IDLE; tcnt=0; all hit flags=0; all stored times=0.
  - busy=0, out_valid=0, out_chan=0, out_hit=0, out_time=0.
  - Synchroniser flops=0.
- Input path:
  - Each tube_pins bit passes through SYNC_STAGES flops to give tube_s[i].
  - Channel i qualifies as hit when tube_s[i]=1, gate_enable=1, state=ARMED and hit[i]=0. Detection is level-based, not edge-based.
- States:
  - IDLE:
    - start=1 → ARMED next cycle, with tcnt=0, hit[]=0, times[]=0.
    - busy rises in the same cycle as entry to ARMED.
  - ARMED:
    - Every cycle, each qualifying channel latches hit[i]=1 and time[i]=tcnt. Several channels may hit in one cycle and receive the same value.
    - A channel already hit is frozen; later pin activity is ignored.
    - tcnt increments by 1 per cycle and never wraps; it saturates at WINDOW.
    - The window closes after the cycle in which tcnt==WINDOW, or after the cycle in which the last unhit channel hits (EARLY_DONE=1). The machine then moves to READOUT with rd_idx=0.
    - Hits in the closing cycle are captured.
    - A channel that has not hit gets out_hit=0 and out_time=all ones.
  - READOUT:
    - out_valid=1; out_chan=rd_idx; out_hit/out_time come from registers.
    - On out_valid&&out_ready, rd_idx increments.
    - After channel N_TUBES-1 is accepted → IDLE; out_valid and busy drop on the next cycle.
    - While out_valid=1 and out_ready=0, all out_* fields are held stable.
- start outside IDLE is ignored; a new measurement needs IDLE.
- abort:
  - From any state, abort → IDLE next cycle; out_valid=0; hit[]/times cleared.
  - abort and start in the same cycle: abort wins; the machine stays in IDLE.
- Latency: a pin rising at cycle k (relative to the first ARMED cycle, tcnt=0) is captured with time=k+SYNC_STAGES, provided that value is ≤ WINDOW.
- Arithmetic: unsigned. tcnt is CNT_W bits wide; the comparison with WINDOW is exact.
- gate_enable low during ARMED blocks capture but tcnt still runs.

Test Plan:
- Reset with all pins low, then start: pin 3 rises 10 cycles after busy rises; all others stay low; WINDOW=255 → window closes after tcnt=255. Readout gives 8 words: chan3 hit=1 time=12; the others hit=0 time=0xFF.
- All 8 pins rise together 5 cycles into ARMED, EARLY_DONE=1 → every channel reports time=7 hit=1; READOUT entered the next cycle, well before tcnt=255.
- gate_enable=0 for the first 20 ARMED cycles with pin 0 held high, then gate_enable=1 → chan0 time=20, hit=1.
- Readout backpressure: out_ready=0 for 4 cycles on chan2 → chan/hit/time stay constant; after 8 accepted words, out_valid=0 and busy=0.
- Mid-ARMED: abort pulse asserted together with start → IDLE next cycle, busy=0, no out_valid. A following start gives a fresh measurement with cleared times.
- Async clr_n low in mid-READOUT, between clock edges → every output is 0 immediately; after release the block waits for start.

Source files
------------

// File: rtl/multi_tube_tdc.sv
// Multi-channel drift-time counter: after a trigger, time each tube's first
// gated hit against a shared counter, then stream per-channel results out.

module multi_tube_tdc_lane #(
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             pin_i,
  input  logic             clear_i,
  input  logic             arm_i,
  input  logic [CNT_W-1:0] tcnt_i,
  output logic             qual_o,
  output logic             hit_o,
  output logic [CNT_W-1:0] time_o
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hit_q;
  logic [CNT_W-1:0]       time_q;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
  end

  // Level-qualified: a channel latches once and then stays frozen until cleared.
  assign qual_o = sync_q[SYNC_STAGES-1] & arm_i & ~hit_q;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      hit_q  <= 1'b0;
      time_q <= '0;
    end else if (clear_i) begin
      hit_q  <= 1'b0;
      time_q <= '0;
    end else if (qual_o) begin
      hit_q  <= 1'b1;
      time_q <= tcnt_i;
    end
  end

  assign hit_o  = hit_q;
  assign time_o = time_q;
endmodule

module multi_tube_tdc #(
  parameter int N_TUBES     = 8,
  parameter int CNT_W       = 8,
  parameter int WINDOW      = 255,
  parameter int SYNC_STAGES = 2,
  parameter int EARLY_DONE  = 1,
  localparam int CH_W       = (N_TUBES > 1) ? $clog2(N_TUBES) : 1
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic               start,
  input  logic               abort,
  input  logic               gate_enable,
  input  logic [N_TUBES-1:0] tube_pins,
  output logic               busy,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CH_W-1:0]    out_chan,
  output logic               out_hit,
  output logic [CNT_W-1:0]   out_time
);
  localparam logic [CNT_W-1:0] WIN      = CNT_W'(WINDOW);
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(N_TUBES - 1);

  typedef enum logic [1:0] {IDLE, ARMED, READOUT} state_t;

  state_t                          state_q, state_d;
  logic [CNT_W-1:0]                tcnt_q, tcnt_d;
  logic [CH_W-1:0]                 rd_idx_q, rd_idx_d;
  logic [N_TUBES-1:0]              qual, hit;
  logic [N_TUBES-1:0][CNT_W-1:0]   times;
  logic                            lane_clear, lane_arm, all_hit;

  // abort dominates start, so a simultaneous pair still leaves lanes cleared.
  assign lane_clear = abort | ((state_q == IDLE) & start);
  assign lane_arm   = (state_q == ARMED) & gate_enable;
  assign all_hit    = &(hit | qual);

  for (genvar i = 0; i < N_TUBES; i++) begin : g_lane
    multi_tube_tdc_lane #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES)) u_lane (
      .clk     (clk),
      .clr_n   (clr_n),
      .pin_i   (tube_pins[i]),
      .clear_i (lane_clear),
      .arm_i   (lane_arm),
      .tcnt_i  (tcnt_q),
      .qual_o  (qual[i]),
      .hit_o   (hit[i]),
      .time_o  (times[i])
    );
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q  <= IDLE;
      tcnt_q   <= '0;
      rd_idx_q <= '0;
    end else begin
      state_q  <= state_d;
      tcnt_q   <= tcnt_d;
      rd_idx_q <= rd_idx_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    tcnt_d   = '0;
    rd_idx_d = rd_idx_q;
    case (state_q)
      IDLE: begin
        rd_idx_d = '0;
        if (start) state_d = ARMED;
      end
      ARMED: begin
        tcnt_d = (tcnt_q == WIN) ? tcnt_q : tcnt_q + 1'b1;
        if ((tcnt_q == WIN) || ((EARLY_DONE != 0) && all_hit)) begin
          state_d  = READOUT;
          rd_idx_d = '0;
        end
      end
      READOUT: begin
        if (out_ready) begin
          if (rd_idx_q == LAST_CH) begin
            state_d  = IDLE;
            rd_idx_d = '0;
          end else begin
            rd_idx_d = rd_idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d  = IDLE;
      tcnt_d   = '0;
      rd_idx_d = '0;
    end
  end

  // Outputs are zero outside READOUT; unhit channels report all ones.
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == READOUT);
  assign out_chan  = out_valid ? rd_idx_q : '0;
  assign out_hit   = out_valid & hit[rd_idx_q];
  assign out_time  = !out_valid       ? '0 :
                     hit[rd_idx_q]    ? times[rd_idx_q] : '1;
endmodule

// File: tb/tb_multi_tube_tdc.sv
// Directed + randomized bench for multi_tube_tdc against a first-hit timing model.

module tb_multi_tube_tdc;
  localparam int N     = 8;
  localparam int CW    = 8;
  localparam int WIN   = 255;
  localparam int SS    = 2;
  localparam int NEVER = 100000;

  logic          clk, clr_n, start, abort, gate_enable, out_ready;
  logic [N-1:0]  tube_pins;
  logic          busy, out_valid, out_hit;
  logic [2:0]    out_chan;
  logic [CW-1:0] out_time;

  int errors = 0;
  int checks = 0;
  int rise [N];
  bit gate [WIN+20];
  int exp_t [N];
  bit exp_h [N];
  int exp_end;

  multi_tube_tdc #(.N_TUBES(N), .CNT_W(CW), .WINDOW(WIN), .SYNC_STAGES(SS), .EARLY_DONE(1)) dut (
    .clk(clk), .clr_n(clr_n), .start(start), .abort(abort), .gate_enable(gate_enable),
    .tube_pins(tube_pins), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_chan(out_chan), .out_hit(out_hit), .out_time(out_time)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Earliest cycle >= rise+SS with gate high; window ends early once all channels hit.
  function automatic void model();
    int mx = 0;
    bit all = 1'b1;
    for (int i = 0; i < N; i++) begin
      exp_h[i] = 1'b0;
      exp_t[i] = 255;
      for (int t = (rise[i] + SS < 0 ? 0 : rise[i] + SS); t <= WIN; t++)
        if (gate[t]) begin
          exp_h[i] = 1'b1;
          exp_t[i] = t;
          break;
        end
      if (!exp_h[i]) all = 1'b0;
      else if (exp_t[i] > mx) mx = exp_t[i];
    end
    exp_end = all ? mx : WIN;
  endfunction

  function automatic logic [N-1:0] pinvec(input int c);
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = (c >= rise[i]);
    return v;
  endfunction

  task automatic gate_all();
    for (int t = 0; t < WIN + 20; t++) gate[t] = 1'b1;
  endtask

  // Idle cycles -4..-1 with start in cycle -1; returns in ARMED cycle 0.
  task automatic arm_seq();
    for (int c = -4; c < 0; c++) begin
      tube_pins   = pinvec(c);
      gate_enable = 1'b1;
      start       = (c == -1);
      step();
    end
    start = 1'b0;
    chk("busy_armed", busy, 1);
    chk("valid_armed", out_valid, 0);
  endtask

  task automatic run_armed(input int lim, output int c);
    c = 0;
    while (!out_valid && c < lim) begin
      tube_pins   = pinvec(c);
      gate_enable = gate[c];
      step();
      c++;
    end
  endtask

  task automatic run_meas(input int stall_ch, input int stall_len, input bit rnd);
    int c, n;
    model();
    arm_seq();
    run_armed(WIN + 10, c);
    chk("rd_entry_cycle", c, exp_end + 1);
    tube_pins = '0;
    for (int ch = 0; ch < N; ch++) begin
      n = (ch == stall_ch) ? stall_len : (rnd ? $urandom_range(0, 2) : 0);
      out_ready = 1'b0;
      for (int s = 0; s < n; s++) begin
        step();
        chk("stall_chan", out_chan, ch);
        chk("stall_time", out_time, exp_t[ch]);
        chk("stall_hit", out_hit, exp_h[ch]);
      end
      chk("valid", out_valid, 1);
      chk("chan", out_chan, ch);
      chk("hit", out_hit, exp_h[ch]);
      chk("time", out_time, exp_t[ch]);
      out_ready = 1'b1;
      step();
    end
    out_ready = 1'b0;
    chk("valid_done", out_valid, 0);
    chk("busy_done", busy, 0);
  endtask

  initial begin
    int c;
    clr_n = 1'b0; start = 1'b0; abort = 1'b0; gate_enable = 1'b1;
    out_ready = 1'b0; tube_pins = '0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_chan", out_chan, 0);
    chk("rst_hit", out_hit, 0);
    chk("rst_time", out_time, 0);
    clr_n = 1'b1;
    step(); step();

    // Single late-ish hit, full window, backpressure on chan2.
    gate_all();
    for (int i = 0; i < N; i++) rise[i] = NEVER;
    rise[3] = 10;
    run_meas(2, 4, 1'b0);

    // All channels together: early close.
    for (int i = 0; i < N; i++) rise[i] = 5;
    run_meas(-1, 0, 1'b0);

    // Gate held low for 20 cycles with pin 0 already high.
    for (int i = 0; i < N; i++) rise[i] = NEVER;
    rise[0] = -4;
    for (int t = 0; t < 20; t++) gate[t] = 1'b0;
    run_meas(-1, 0, 1'b0);
    gate_all();

    // Window edge: 255 captured, 256 missed.
    for (int i = 0; i < N; i++) rise[i] = NEVER;
    rise[1] = 253;
    rise[2] = 254;
    run_meas(-1, 0, 1'b0);

    // Abort with start mid-ARMED, then a fresh measurement.
    for (int i = 0; i < N; i++) rise[i] = (i < 4) ? 3 : NEVER;
    model();
    arm_seq();
    run_armed(15, c);
    abort = 1'b1; start = 1'b1;
    step();
    abort = 1'b0; start = 1'b0; tube_pins = '0;
    chk("abort_busy", busy, 0);
    chk("abort_valid", out_valid, 0);
    for (int k = 0; k < 4; k++) step();
    chk("abort_idle_valid", out_valid, 0);
    chk("abort_idle_busy", busy, 0);
    for (int i = 0; i < N; i++) rise[i] = (i < 4) ? NEVER : $urandom_range(0, 30);
    run_meas(-1, 0, 1'b1);

    // Async clear in the middle of readout.
    for (int i = 0; i < N; i++) rise[i] = $urandom_range(0, 20);
    model();
    arm_seq();
    run_armed(WIN + 10, c);
    chk("clr_rd_entry", c, exp_end + 1);
    tube_pins = '0;
    out_ready = 1'b1;
    step(); step(); step();
    out_ready = 1'b0;
    chk("clr_pre_chan", out_chan, 3);
    #2 clr_n = 1'b0;
    #1;
    chk("clr_busy", busy, 0);
    chk("clr_valid", out_valid, 0);
    chk("clr_chan", out_chan, 0);
    chk("clr_hit", out_hit, 0);
    chk("clr_time", out_time, 0);
    #1 clr_n = 1'b1;
    for (int k = 0; k < 5; k++) step();
    chk("clr_wait_busy", busy, 0);
    chk("clr_wait_valid", out_valid, 0);

    // Randomized measurements.
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < N; i++)
        rise[i] = ($urandom_range(0, 3) == 0) ? NEVER : $urandom_range(0, 40);
      for (int t = 0; t < WIN + 20; t++) gate[t] = ($urandom_range(0, 7) != 0);
      run_meas(-1, 0, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
